// File: rtl/guess_pkg.sv
// Shared types and sizes for the guess_checker round controller.
package guess_pkg;
    localparam int TILE_COUNT = 8;
    localparam int IDX_W      = 3;
    localparam int MISS_W     = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW  = 3'd1,
        GUESS = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_t;
endpackage

// File: rtl/guess_checker_if.sv
// Board/guess/result bundle between the player front end and the round controller.
interface guess_checker_if
    import guess_pkg::*;
#(
    parameter int SCORE_W = 8
);
    logic [TILE_COUNT-1:0] board;
    logic                  board_valid;
    logic [IDX_W-1:0]      guess_idx;
    logic                  guess_strobe;
    logic                  ack;
    logic [TILE_COUNT-1:0] show_board;
    logic [TILE_COUNT-1:0] revealed;
    logic [MISS_W-1:0]     misses;
    logic                  busy;
    logic                  win;
    logic                  lose;
    logic [SCORE_W-1:0]    score;

    modport master (
        output board, board_valid, guess_idx, guess_strobe, ack,
        input  show_board, revealed, misses, busy, win, lose, score
    );

    modport slave (
        input  board, board_valid, guess_idx, guess_strobe, ack,
        output show_board, revealed, misses, busy, win, lose, score
    );
endinterface

// File: rtl/tile_judge.sv
// Classifies one guess against the captured board and the tiles already revealed.
module tile_judge
    import guess_pkg::*;
(
    input  logic [TILE_COUNT-1:0] board_q,
    input  logic [TILE_COUNT-1:0] revealed,
    input  logic [IDX_W-1:0]      guess_idx,
    output logic                  hit,
    output logic                  repeat_hit,
    output logic                  miss,
    output logic [TILE_COUNT-1:0] next_revealed
);
    logic lit;
    logic seen;

    always_comb begin
        lit           = board_q[guess_idx];
        seen          = revealed[guess_idx];
        hit           = lit & ~seen;
        repeat_hit    = lit & seen;
        miss          = ~lit;
        next_revealed = revealed | (hit ? (TILE_COUNT'(1) << guess_idx) : '0);
    end
endmodule

// File: rtl/guess_checker.sv
// Round controller: capture board, show it, judge guesses, report win/lose and score.
// Optional guess-phase timeout when TIMEOUT_EN is defined.
module guess_checker
    import guess_pkg::*;
#(
    parameter int SHOW_CYCLES   = 50_000_000,
    parameter int MAX_MISSES    = 3,
    parameter int SCORE_W       = 8,
    parameter int GUESS_TIMEOUT = 500_000_000
) (
    input  logic            clk,
    input  logic            reset,
    guess_checker_if.slave  bus
);
    localparam int SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    state_t                state, state_n;
    logic [TILE_COUNT-1:0] board_q, board_n;
    logic [TILE_COUNT-1:0] rev_q, rev_n;
    logic [MISS_W-1:0]     miss_q, miss_n;
    logic [SCORE_W-1:0]    score_q, score_n;
    logic [SHOW_W-1:0]     show_cnt, show_cnt_n;
    logic [TILE_COUNT-1:0] show_q, show_n;
    logic                  busy_q, busy_n, win_q, win_n, lose_q, lose_n;
    logic                  j_hit, j_repeat, j_miss;
    logic [TILE_COUNT-1:0] j_next_rev;

`ifdef TIMEOUT_EN
    localparam int TMO_W = (GUESS_TIMEOUT > 1) ? $clog2(GUESS_TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
`endif

    tile_judge u_judge (
        .board_q       (board_q),
        .revealed      (rev_q),
        .guess_idx     (bus.guess_idx),
        .hit           (j_hit),
        .repeat_hit    (j_repeat),
        .miss          (j_miss),
        .next_revealed (j_next_rev)
    );

    always_comb begin
        state_n    = state;
        board_n    = board_q;
        rev_n      = rev_q;
        miss_n     = miss_q;
        score_n    = score_q;
        show_cnt_n = show_cnt;
`ifdef TIMEOUT_EN
        tmo_cnt_n  = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (bus.board_valid && (bus.board != '0)) begin
                    board_n    = bus.board;
                    rev_n      = '0;
                    miss_n     = '0;
                    show_cnt_n = SHOW_W'(SHOW_CYCLES - 1);
                    state_n    = SHOW;
                end
            end
            SHOW: begin
                if (show_cnt == '0) begin
                    state_n = GUESS;
`ifdef TIMEOUT_EN
                    tmo_cnt_n = TMO_W'(GUESS_TIMEOUT - 1);
`endif
                end else begin
                    show_cnt_n = show_cnt - 1'b1;
                end
            end
            GUESS: begin
                if (bus.guess_strobe) begin
                    if (j_hit)
                        rev_n = j_next_rev;
                    else if (j_miss)
                        miss_n = miss_q + 1'b1;
                    else if (j_repeat)
                        rev_n = rev_q;  // already revealed: not a miss, nothing changes
                end
                // round end is judged on the updated values so the result lands one cycle after the strobe
                if (rev_n == board_q) begin
                    state_n = WIN;
                    if (score_q != '1)
                        score_n = score_q + 1'b1;
                end else if (miss_n == MISS_W'(MAX_MISSES)) begin
                    state_n = LOSE;
`ifdef TIMEOUT_EN
                end else if (tmo_cnt == '0) begin
                    state_n = LOSE;
                end else begin
                    tmo_cnt_n = tmo_cnt - 1'b1;
`endif
                end
            end
            WIN, LOSE: begin
                if (bus.ack)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        show_n = (state_n == SHOW) ? board_n : '0;
        busy_n = (state_n == SHOW) || (state_n == GUESS);
        win_n  = (state_n == WIN);
        lose_n = (state_n == LOSE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            board_q  <= '0;
            rev_q    <= '0;
            miss_q   <= '0;
            score_q  <= '0;
            show_cnt <= '0;
            show_q   <= '0;
            busy_q   <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            state    <= state_n;
            board_q  <= board_n;
            rev_q    <= rev_n;
            miss_q   <= miss_n;
            score_q  <= score_n;
            show_cnt <= show_cnt_n;
            show_q   <= show_n;
            busy_q   <= busy_n;
            win_q    <= win_n;
            lose_q   <= lose_n;
        end
    end

`ifdef TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt_n;
    end
`endif

    assign bus.show_board = show_q;
    assign bus.revealed   = rev_q;
    assign bus.misses     = miss_q;
    assign bus.busy       = busy_q;
    assign bus.win        = win_q;
    assign bus.lose       = lose_q;
    assign bus.score      = score_q;
endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker; expected guess results go through a scoreboard queue.
module tb_guess_checker;
    localparam int SHOW_CYCLES   = 4;
    localparam int MAX_MISSES    = 3;
    localparam int SCORE_W       = 8;
    localparam int GUESS_TIMEOUT = 10;

    typedef struct {
        logic [7:0] rev;
        logic [3:0] miss;
        logic       win;
        logic       lose;
        logic [7:0] score;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] m_board;
    logic [7:0] m_rev;
    logic [3:0] m_miss;
    logic [7:0] m_score;
    exp_t       exp_q[$];

    guess_checker_if #(.SCORE_W(SCORE_W)) bus ();

    guess_checker #(
        .SHOW_CYCLES   (SHOW_CYCLES),
        .MAX_MISSES    (MAX_MISSES),
        .SCORE_W       (SCORE_W),
        .GUESS_TIMEOUT (GUESS_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [7:0] b);
        bus.board       = b;
        bus.board_valid = 1'b1;
        tick();
        bus.board_valid = 1'b0;
        m_board = b;
        m_rev   = '0;
        m_miss  = '0;
    endtask

    task automatic pass_show();
        repeat (SHOW_CYCLES) tick();
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic do_guess(input logic [2:0] idx);
        exp_t e;
        exp_t got;
        if (m_board[idx]) m_rev[idx] = 1'b1;
        else              m_miss = m_miss + 4'd1;
        e.win  = (m_rev == m_board);
        e.lose = !e.win && (m_miss == 4'(MAX_MISSES));
        if (e.win && m_score != 8'hFF) m_score = m_score + 8'd1;
        e.rev   = m_rev;
        e.miss  = m_miss;
        e.score = m_score;
        exp_q.push_back(e);

        bus.guess_idx    = idx;
        bus.guess_strobe = 1'b1;
        tick();
        bus.guess_strobe = 1'b0;

        got = exp_q.pop_front();
        checks++;
        if (bus.revealed !== got.rev) begin
            failures++;
            $display("FAIL guess_revealed idx=%0d got=%h exp=%h", idx, bus.revealed, got.rev);
        end
        checks++;
        if (bus.misses !== got.miss) begin
            failures++;
            $display("FAIL guess_misses idx=%0d got=%0d exp=%0d", idx, bus.misses, got.miss);
        end
        checks++;
        if (bus.win !== got.win || bus.lose !== got.lose) begin
            failures++;
            $display("FAIL guess_result idx=%0d got win=%b lose=%b exp win=%b lose=%b",
                     idx, bus.win, bus.lose, got.win, got.lose);
        end
        checks++;
        if (bus.score !== got.score) begin
            failures++;
            $display("FAIL guess_score idx=%0d got=%0d exp=%0d", idx, bus.score, got.score);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.board = '0; bus.board_valid = 1'b0; bus.guess_idx = '0;
        bus.guess_strobe = 1'b0; bus.ack = 1'b0;
        m_score = '0;
        #12;
        checks++;
        if ({bus.show_board, bus.revealed, bus.misses, bus.busy, bus.win, bus.lose, bus.score} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got show=%h rev=%h miss=%0d busy=%b win=%b lose=%b score=%0d exp all 0",
                     bus.show_board, bus.revealed, bus.misses, bus.busy, bus.win, bus.lose, bus.score);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_capture_show();
        start_round(8'hA5);
        for (int i = 0; i < SHOW_CYCLES; i++) begin
            checks++;
            if (bus.show_board !== 8'hA5 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL show_cycle%0d got show=%h busy=%b exp show=a5 busy=1", i, bus.show_board, bus.busy);
            end
            tick();
        end
        checks++;
        if (bus.show_board !== 8'h00 || bus.busy !== 1'b1 || bus.win !== 1'b0 || bus.lose !== 1'b0) begin
            failures++;
            $display("FAIL show_end got show=%h busy=%b win=%b lose=%b exp show=00 busy=1 win=0 lose=0",
                     bus.show_board, bus.busy, bus.win, bus.lose);
        end
        do_guess(3'd1);
        do_guess(3'd3);
        do_guess(3'd4);
        do_ack();
    endtask

    task automatic test_win();
        start_round(8'h81);
        pass_show();
        do_guess(3'd0);
        do_guess(3'd0);
        do_guess(3'd7);
        do_ack();
        checks++;
        if (bus.win !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL win_ack got win=%b busy=%b exp 0 0", bus.win, bus.busy);
        end
    endtask

    task automatic test_lose();
        start_round(8'h01);
        pass_show();
        do_guess(3'd1);
        do_guess(3'd2);
        do_guess(3'd3);
        // ack together with a fresh board: the board must not be taken
        bus.board       = 8'h33;
        bus.board_valid = 1'b1;
        bus.ack         = 1'b1;
        tick();
        bus.board_valid = 1'b0;
        bus.ack         = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.win !== 1'b0 || bus.lose !== 1'b0 || bus.score !== m_score) begin
            failures++;
            $display("FAIL lose_ack got busy=%b win=%b lose=%b score=%0d exp 0 0 0 %0d",
                     bus.busy, bus.win, bus.lose, bus.score, m_score);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.show_board !== 8'h00) begin
            failures++;
            $display("FAIL ack_board_ignored got busy=%b show=%h exp 0 00", bus.busy, bus.show_board);
        end
    endtask

    task automatic test_ignored();
        bus.board       = 8'h00;
        bus.board_valid = 1'b1;
        tick();
        bus.board_valid = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_board got busy=%b exp 0", bus.busy);
        end

        start_round(8'h81);
        bus.guess_idx    = 3'd0;
        bus.guess_strobe = 1'b1;
        tick();
        bus.guess_strobe = 1'b0;
        checks++;
        if (bus.revealed !== 8'h00 || bus.show_board !== 8'h81) begin
            failures++;
            $display("FAIL show_strobe got rev=%h show=%h exp 00 81", bus.revealed, bus.show_board);
        end
        repeat (SHOW_CYCLES - 1) tick();

        bus.board       = 8'h02;
        bus.board_valid = 1'b1;
        tick();
        bus.board_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.show_board !== 8'h00) begin
            failures++;
            $display("FAIL guess_board_valid got busy=%b show=%h exp 1 00", bus.busy, bus.show_board);
        end
        do_guess(3'd1);
        do_guess(3'd0);
        do_guess(3'd7);
        do_ack();
    endtask

    task automatic test_async_reset();
        start_round(8'h0C);
        pass_show();
        do_guess(3'd2);
        #3;
        rst_n = 1'b0;
        #1;
        m_score = '0;
        checks++;
        if ({bus.show_board, bus.revealed, bus.misses, bus.busy, bus.win, bus.lose, bus.score} !== '0) begin
            failures++;
            $display("FAIL async_reset got rev=%h miss=%0d busy=%b score=%0d exp all 0",
                     bus.revealed, bus.misses, bus.busy, bus.score);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        start_round(8'h01);
        pass_show();
`ifdef TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (!bus.lose && n < 50) begin
                tick();
                n++;
            end
            checks++;
            if (n != GUESS_TIMEOUT) begin
                failures++;
                $display("FAIL timeout_cycles got=%0d exp=%0d", n, GUESS_TIMEOUT);
            end
        end
`else
        repeat (100) tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.lose !== 1'b0 || bus.win !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout got busy=%b lose=%b win=%b exp 1 0 0", bus.busy, bus.lose, bus.win);
        end
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_capture_show();
        test_win();
        test_lose();
        test_ignored();
        test_async_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/guess_checker.md
Name: guess_checker

Overview:
- Round controller downstream of the board generator. Captures one non-zero 8-tile board and shows it for a fixed time, then hides it.
- Accepts tile guesses from the player and tracks which tiles have been correctly recalled. Ends the round as win or lose.
- Feeds the display (show/reveal masks) and the score/HEX logic.

Parameters:
- SHOW_CYCLES, 50_000_000, clock cycles the board stays visible (>=1).
- MAX_MISSES, 3, wrong guesses that end the round (1..15).
- SCORE_W, 8, width of the saturating win counter.
- GUESS_TIMEOUT, 500_000_000, guess-phase limit in cycles (used only with TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- board  in  8  tile pattern from the board generator; bit i set = tile i lit.
- board_valid  in  1  single-cycle pulse: board is stable and should be captured.
- guess_idx  in  3  tile index being guessed.
- guess_strobe  in  1  single-cycle pulse (already debounced): guess_idx is a guess.
- ack  in  1  level; acknowledges the result and returns to IDLE.
- show_board  out  8  board_q while in SHOW, else 0.
- revealed  out  8  tiles correctly guessed this round.
- misses  out  4  wrong guesses this round.
- busy  out  1  high in SHOW or GUESS.
- win  out  1  high while in WIN.
- lose  out  1  high while in LOSE.
- score  out  SCORE_W  rounds won since reset; saturates at all-ones.

Behaviour:
- Reset values: all outputs 0; state IDLE; board_q = 0; all counters 0.
- All outputs are registered.

State machine:
- IDLE:
  - board_valid && board != 0: capture board into board_q, clear revealed and misses, load show counter with SHOW_CYCLES-1, go to SHOW.
  - board_valid with board == 0: ignored, stay in IDLE.
- SHOW:
  - show_board = board_q for exactly SHOW_CYCLES cycles. Counter decrements each cycle; at 0, go to GUESS.
  - guess_strobe and board_valid are ignored.
- GUESS, evaluated on each guess_strobe:
  - Hit: board_q[guess_idx]=1 and revealed[guess_idx]=0. Set revealed[guess_idx].
  - Repeat hit: board_q[guess_idx]=1 and revealed[guess_idx]=1. No change; it is not a miss.
  - Miss: board_q[guess_idx]=0. misses increments.
- Round end (checked on the next-state values):
  - revealed == board_q: go to WIN and increment score (saturating).
  - misses == MAX_MISSES: go to LOSE.
  - The completing guess is visible on win/lose one cycle after the strobe edge.
  - Win and lose are mutually exclusive by construction: a single guess cannot both hit and miss.
- WIN / LOSE:
  - Hold revealed and misses.
  - ack=1: go to IDLE. ack is sampled every cycle; holding it in IDLE is harmless.
  - board_valid is ignored until back in IDLE.
  - A board_valid arriving in the same cycle as the transition to IDLE is not captured.
- Mid-round board_valid (SHOW/GUESS): ignored. The upstream board may change freely; board_q is the reference for the whole round.
- Asynchronous reset mid-round aborts the round; score is cleared as well.

Optional Feature:
- Macro TIMEOUT_EN.
- Defined:
  - A guess-phase counter loads GUESS_TIMEOUT-1 on entry to GUESS and decrements each GUESS cycle.
  - On reaching 0 with no win, go to LOSE. A win on the same edge takes priority.
  - Counter width is $clog2(GUESS_TIMEOUT).
- Undefined: no counter is built; GUESS waits indefinitely.

Decomposition:
- Package guess_pkg holds:
  - state enum (IDLE, SHOW, GUESS, WIN, LOSE; 3-bit encoding);
  - TILE_COUNT=8;
  - IDX_W=3;
  - MISS_W=4.
- Sub-module: tile_judge, combinational. Inputs board_q, revealed, guess_idx. Outputs hit, repeat_hit, miss, next_revealed. It is instantiated once by the FSM.

Test Plan:
- Capture and show: SHOW_CYCLES=4, board=8'hA5 with board_valid pulse → show_board=8'hA5 and busy=1 for exactly 4 cycles, then show_board=0 and state GUESS.
- Win path: board 8'h81, guesses idx 0, 0, 7 → revealed 01, 01, 81. win=1 one cycle after the third strobe; score 0→1; misses=0.
- Lose path: MAX_MISSES=3, board 8'h01, guesses 1, 2, 3 → misses 1, 2, 3 and lose=1. ack → IDLE with all flags 0; score unchanged.
- Ignored inputs: board_valid with 8'h00 in IDLE → stays IDLE. guess_strobe during SHOW → revealed stays 0. board_valid during GUESS → board_q unchanged.
- Async reset mid-GUESS with revealed=8'h04, score=2 → all outputs 0 immediately, without a clock edge.
- TIMEOUT_EN, GUESS_TIMEOUT=10: no guesses → lose=1 after 10 GUESS cycles. Same run without the macro → still in GUESS after 100 cycles.
